// File: rtl/prog_loader.sv
// Byte-stream program loader: assembles 3-byte big-endian words into instruction memory
// and holds the CPU in reset until the requested number of words has been written.
module prog_loader #(
  parameter int unsigned INSTR_WIDTH = 18,
  parameter int unsigned ADDR_WIDTH  = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_WIDTH:0]     word_count,
  input  logic                    in_valid,
  input  logic [7:0]              in_data,
  output logic                    in_ready,
  output logic                    imem_we,
  output logic [ADDR_WIDTH-1:0]   imem_addr,
  output logic [INSTR_WIDTH-1:0]  imem_wdata,
  output logic                    cpu_reset,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StWrite,
    StDone
  } state_e;

  localparam logic [ADDR_WIDTH:0] MaxCount = (ADDR_WIDTH + 1)'(1) << ADDR_WIDTH;

  state_e                   state_q, state_d;
  logic [ADDR_WIDTH:0]      count_q, count_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [1:0]               byte_cnt_q, byte_cnt_d;
  logic [INSTR_WIDTH-1:0]   wdata_q, wdata_d;
  logic                     error_q, error_d;

  logic start_ok;
  logic accept;
  logic last_word;

  // Only the low two bits of the first byte carry instruction bits.
  logic unused_in_data;
  assign unused_in_data = ^in_data[7:2];

  assign start_ok  = start && (word_count != '0) && (word_count <= MaxCount);
  assign accept    = in_valid && in_ready;
  assign last_word = ({1'b0, addr_q} == (count_q - (ADDR_WIDTH + 1)'(1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      count_q    <= '0;
      addr_q     <= '0;
      byte_cnt_q <= '0;
      wdata_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      byte_cnt_q <= byte_cnt_d;
      wdata_q    <= wdata_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    addr_d     = addr_q;
    byte_cnt_d = byte_cnt_q;
    wdata_d    = wdata_q;
    error_d    = error_q;

    unique case (state_q)
      StIdle, StDone: begin
        // A new start is honoured both before the first load and after a completed one.
        if (start) begin
          if (start_ok) begin
            count_d    = word_count;
            error_d    = 1'b0;
            addr_d     = '0;
            byte_cnt_d = '0;
            state_d    = StRecv;
          end else begin
            error_d = 1'b1;
          end
        end
      end

      StRecv: begin
        if (accept) begin
          unique case (byte_cnt_q)
            2'd0: begin
              wdata_d[17:16] = in_data[1:0];
              byte_cnt_d     = 2'd1;
            end
            2'd1: begin
              wdata_d[15:8] = in_data;
              byte_cnt_d    = 2'd2;
            end
            2'd2: begin
              wdata_d[7:0] = in_data;
              byte_cnt_d   = 2'd0;
              state_d      = StWrite;
            end
            default: byte_cnt_d = 2'd0;
          endcase
        end
      end

      StWrite: begin
        if (last_word) begin
          state_d = StDone;
        end else begin
          addr_d     = addr_q + ADDR_WIDTH'(1);
          byte_cnt_d = '0;
          state_d    = StRecv;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready   = (state_q == StRecv);
    imem_we    = (state_q == StWrite);
    busy       = (state_q == StRecv) || (state_q == StWrite);
    done       = (state_q == StDone);
    cpu_reset  = (state_q != StDone);
    error      = error_q;
    imem_addr  = addr_q;
    imem_wdata = wdata_q;
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader: a queue of expected memory writes is
// built from the words sent and compared against every observed write strobe.
module tb_prog_loader;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   word_count;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [17:0]   imem_wdata;
  logic          cpu_reset;
  logic          busy;
  logic          done;
  logic          error;

  prog_loader #(.INSTR_WIDTH(18), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned addr;
    logic [17:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int unsigned we_cycles[$];
  logic [17:0] words[1024];
  int unsigned cyc = 0;
  int unsigned done_cyc;
  int          errors = 0;
  int          checks = 0;
  wr_t         mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every write strobe must match the next expected write, with the byte port closed.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      check_eq("we_in_ready", in_ready, 0);
      if (exp_q.size() == 0) begin
        check_eq("we_unexpected", imem_we, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("we_addr", imem_addr, mon_e.addr);
        check_eq("we_data", imem_wdata, mon_e.data);
      end
      we_cycles.push_back(cyc);
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit acc;
    if (gap) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    acc = 1'b0;
    for (int k = 0; k < 64 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    if (!acc) check_eq("byte_timeout", in_ready, 1);
  endtask

  task automatic start_load(input int n);
    start      = 1'b1;
    word_count = (AW + 1)'(n);
    @(posedge clk); #1;
    start      = 1'b0;
    word_count = (AW + 1)'($urandom);
    @(negedge clk);
    check_eq("start_in_ready", in_ready, 1);
    check_eq("start_busy", busy, 1);
    check_eq("start_cpu_reset", cpu_reset, 1);
    check_eq("start_done", done, 0);
    check_eq("start_error", error, 0);
    @(posedge clk); #1;
  endtask

  task automatic bad_start(input int n, input bit exp_done);
    start      = 1'b1;
    word_count = (AW + 1)'(n);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_eq("bad_error", error, 1);
    check_eq("bad_in_ready", in_ready, 0);
    check_eq("bad_busy", busy, 0);
    check_eq("bad_done", done, exp_done);
    check_eq("bad_cpu_reset", cpu_reset, !exp_done);
    @(posedge clk); #1;
  endtask

  // hi < 0 randomizes the ignored upper bits of each first byte.
  task automatic do_load(input int n, input bit gap, input int hi, input bit poke);
    logic [31:0] rv;
    logic [7:0]  b0;
    bit          got;
    start_load(n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{addr: i, data: words[i]});
      rv = $urandom;
      b0 = {(hi < 0) ? rv[5:0] : 6'(hi), words[i][17:16]};
      send_byte(b0, gap);
      if (poke && i == 1) begin
        in_valid   = 1'b0;
        start      = 1'b1;
        word_count = (AW + 1)'(n + 5);
        @(posedge clk); #1;
        start = 1'b0;
      end
      send_byte(words[i][15:8], gap);
      send_byte(words[i][7:0], gap);
    end
    in_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = done;
      if (!got) begin
        @(posedge clk); #1;
      end
    end
    done_cyc = cyc;
    check_eq("load_done", done, 1);
    check_eq("load_cpu_reset", cpu_reset, 0);
    check_eq("load_busy", busy, 0);
    check_eq("load_last_addr", imem_addr, n - 1);
    check_eq("load_pending", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) words[i] = 18'($urandom);
  endtask

  initial begin
    logic [31:0] rv;
    reset      = 1'b1;
    start      = 1'b0;
    word_count = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    #2;
    check_eq("rst_cpu_reset", cpu_reset, 1);
    check_eq("rst_done", done, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_error", error, 0);
    check_eq("rst_we", imem_we, 0);
    check_eq("rst_addr", imem_addr, 0);
    check_eq("rst_wdata", imem_wdata, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check_eq("idle_cpu_reset", cpu_reset, 1);
    check_eq("idle_in_ready", in_ready, 0);
    @(posedge clk); #1;

    // Two-word load with in_valid held high: writes 4 cycles apart, done right after.
    words[0] = 18'h08004;
    words[1] = 18'h24000;
    do_load(2, 1'b0, 0, 1'b0);
    check_eq("nogap_spacing", we_cycles[$] - we_cycles[$-1], 4);
    check_eq("nogap_done_lat", done_cyc - we_cycles[$], 1);

    do_load(2, 1'b1, 0, 1'b0);

    words[0] = 18'h3FFFF;
    do_load(1, 1'b0, 63, 1'b0);

    bad_start(0, 1'b1);
    bad_start(1025, 1'b1);
    fill_random(3);
    do_load(3, 1'b0, -1, 1'b0);

    // Reset in the middle of word 1; word 0 must already be written.
    fill_random(2);
    start_load(2);
    exp_q.push_back('{addr: 0, data: words[0]});
    send_byte({6'h15, words[0][17:16]}, 1'b0);
    send_byte(words[0][15:8], 1'b0);
    send_byte(words[0][7:0], 1'b0);
    send_byte({6'h2A, words[1][17:16]}, 1'b0);
    send_byte(words[1][15:8], 1'b0);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_eq("mid_cpu_reset", cpu_reset, 1);
    check_eq("mid_in_ready", in_ready, 0);
    check_eq("mid_busy", busy, 0);
    check_eq("mid_done", done, 0);
    check_eq("mid_addr", imem_addr, 0);
    check_eq("mid_wdata", imem_wdata, 0);
    check_eq("mid_pending", exp_q.size(), 0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;

    bad_start(0, 1'b0);
    bad_start(1025, 1'b0);
    fill_random(1);
    do_load(1, 1'b0, -1, 1'b0);
    fill_random(3);
    do_load(3, 1'b1, -1, 1'b1);

    for (int r = 0; r < 6; r++) begin
      rv = $urandom_range(24, 1);
      fill_random(int'(rv));
      do_load(int'(rv), 1'(r % 2), -1, (rv >= 2) && (r % 3 == 0));
    end

    // Full-depth load exercises the top address and the count == depth boundary.
    fill_random(1024);
    do_load(1024, 1'b0, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
